// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM encodings, default operand width,
// and iteration-counter sizing for the shift-and-add/subtract units.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 16;

    // Counter must hold the value 2*w (one iteration per dividend bit)
    function automatic int unsigned iter_width(input int unsigned w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/twos_abs.sv
// Combinational two's-complement magnitude and sign extraction.
// The most negative value maps to its unsigned magnitude (e.g. 0x8000 -> 0x8000).
module twos_abs
    import arith_pkg::*;
#(
    parameter int unsigned W = DEFAULT_WIDTH
) (
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_mag_c,
    output logic         o_neg_c
);

    assign o_neg_c = i_x[W-1];
    assign o_mag_c = i_x[W-1] ? -i_x : i_x;

endmodule

// File: rtl/signed_divider_32by16.sv
// Signed restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per cycle.
// Optional quotient saturation with overflow flag: define DIV_OVF_SATURATE_EN.
module signed_divider_32by16
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2*WIDTH-1:0]   N,
    input  logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     R,
    output logic                 flag,
    output logic                 busy,
    output logic                 dbz,
    output logic                 ovf
);

    localparam int unsigned NW = 2 * WIDTH;
    localparam int unsigned IW = iter_width(WIDTH);
    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned TW = WIDTH + 2;

    state_t r_state;
    state_t w_state_nxt;

    logic [NW-1:0]    w_abs_n;
    logic [WIDTH-1:0] w_abs_d;
    logic             w_neg_n;
    logic             w_neg_d;

    logic [NW-1:0]    r_quo;
    logic [RW-1:0]    r_rem;
    logic [WIDTH-1:0] r_abs_d;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_n_low;
    logic [IW-1:0]    r_iter;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_flag;
    logic             r_busy;
    logic             r_dbz;
    logic             r_ovf;

    logic [NW-1:0]    w_quo_nxt;
    logic [RW-1:0]    w_rem_nxt;
    logic [WIDTH-1:0] w_abs_d_nxt;
    logic             w_sign_q_nxt;
    logic             w_sign_r_nxt;
    logic [WIDTH-1:0] w_n_low_nxt;
    logic [IW-1:0]    w_iter_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_r_nxt;
    logic             w_flag_nxt;
    logic             w_busy_nxt;
    logic             w_dbz_nxt;
    logic             w_ovf_nxt;

    logic [TW-1:0]    w_shift;
    logic [TW-1:0]    w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_q_wrap;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_ovf_c;

    twos_abs #(.W(NW)) u_abs_n (
        .i_x     (N),
        .o_mag_c (w_abs_n),
        .o_neg_c (w_neg_n)
    );

    twos_abs #(.W(WIDTH)) u_abs_d (
        .i_x     (D),
        .o_mag_c (w_abs_d),
        .o_neg_c (w_neg_d)
    );

    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits
    assign w_shift = {r_rem, r_quo[NW-1]};
    assign w_trial = w_shift - TW'(r_abs_d);
    assign w_ge    = (w_shift >= TW'(r_abs_d));

    assign w_q_mag  = r_quo[WIDTH-1:0];
    assign w_q_wrap = r_sign_q ? -w_q_mag : w_q_mag;
    assign w_r_fix  = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

`ifdef DIV_OVF_SATURATE_EN
    localparam logic [NW-1:0] LIM_POS = NW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [NW-1:0] LIM_NEG = NW'(64'd1 << (WIDTH - 1));

    assign w_ovf_c = r_sign_q ? (r_quo > LIM_NEG) : (r_quo > LIM_POS);
    assign w_q_fix = !w_ovf_c ? w_q_wrap :
                     (r_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign w_ovf_c = 1'b0;
    assign w_q_fix = w_q_wrap;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE exits only once the result has been presented and en is low
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = (r_abs_d == '0) ? ST_DONE : ST_CALC;
            ST_CALC: if (r_iter <= IW'(1)) w_state_nxt = ST_DONE;
            ST_DONE: if (r_flag && !en) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        w_quo_nxt    = r_quo;
        w_rem_nxt    = r_rem;
        w_abs_d_nxt  = r_abs_d;
        w_sign_q_nxt = r_sign_q;
        w_sign_r_nxt = r_sign_r;
        w_n_low_nxt  = r_n_low;
        w_iter_nxt   = r_iter;
        w_q_nxt      = r_q;
        w_r_nxt      = r_r;
        w_flag_nxt   = r_flag;
        w_dbz_nxt    = r_dbz;
        w_ovf_nxt    = r_ovf;
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_quo_nxt    = w_abs_n;
                    w_abs_d_nxt  = w_abs_d;
                    w_sign_q_nxt = w_neg_n ^ w_neg_d;
                    w_sign_r_nxt = w_neg_n;
                    w_n_low_nxt  = N[WIDTH-1:0];
                end
            end
            ST_LOAD: begin
                if (r_abs_d != '0) begin
                    w_rem_nxt  = '0;
                    w_iter_nxt = IW'(NW);
                end
            end
            ST_CALC: begin
                if (r_iter != '0) begin
                    w_quo_nxt  = {r_quo[NW-2:0], w_ge};
                    w_rem_nxt  = RW'(w_ge ? w_trial : w_shift);
                    w_iter_nxt = r_iter - IW'(1);
                end
            end
            ST_DONE: begin
                if (!r_flag) begin
                    w_flag_nxt = 1'b1;
                    if (r_abs_d == '0) begin
                        w_q_nxt   = '1;
                        w_r_nxt   = r_n_low;
                        w_dbz_nxt = 1'b1;
                        w_ovf_nxt = 1'b0;
                    end else begin
                        w_q_nxt   = w_q_fix;
                        w_r_nxt   = w_r_fix;
                        w_dbz_nxt = 1'b0;
                        w_ovf_nxt = w_ovf_c;
                    end
                end else if (!en) begin
                    w_flag_nxt = 1'b0;
                    w_dbz_nxt  = 1'b0;
                    w_ovf_nxt  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset discards any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_abs_d  <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_n_low  <= '0;
            r_iter   <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_flag   <= 1'b0;
            r_busy   <= 1'b0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_quo    <= w_quo_nxt;
            r_rem    <= w_rem_nxt;
            r_abs_d  <= w_abs_d_nxt;
            r_sign_q <= w_sign_q_nxt;
            r_sign_r <= w_sign_r_nxt;
            r_n_low  <= w_n_low_nxt;
            r_iter   <= w_iter_nxt;
            r_q      <= w_q_nxt;
            r_r      <= w_r_nxt;
            r_flag   <= w_flag_nxt;
            r_busy   <= w_busy_nxt;
            r_dbz    <= w_dbz_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign flag = r_flag;
    assign busy = r_busy;
    assign dbz  = r_dbz;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_signed_divider_32by16.sv
// Scoreboard bench for signed_divider_32by16: directed vectors with hand-computed results.
// Expected overflow/saturation values follow DIV_OVF_SATURATE_EN when it is defined.
module tb_signed_divider_32by16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] N;
    logic [15:0] D;
    logic [15:0] Q;
    logic [15:0] R;
    logic        flag;
    logic        busy;
    logic        dbz;
    logic        ovf;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
        int          start;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic flag_d = 1'b0;

    signed_divider_32by16 #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .N    (N),
        .D    (D),
        .Q    (Q),
        .R    (R),
        .flag (flag),
        .busy (busy),
        .dbz  (dbz),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare against the scoreboard on each rising edge of flag
    always @(negedge clk) begin
        if (!rst && flag && !flag_d) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty: unexpected result Q=%h R=%h", Q, R);
            end else begin
                mon_e = sb.pop_front();
                check("Q", 32'(Q), 32'(mon_e.q));
                check("R", 32'(R), 32'(mon_e.r));
                check("dbz", 32'(dbz), 32'(mon_e.dbz));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
                check("latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
            end
        end
        flag_d = flag;
    end

    task automatic run_op(input logic [31:0] n, input logic [15:0] d,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edbz, input logic eovf, input int lat, input bit hold);
        exp_t x;
        bit   seen;
        @(negedge clk);
        N  = n;
        D  = d;
        en = 1'b1;
        @(posedge clk);
        #1;
        x.q = eq; x.r = er; x.dbz = edbz; x.ovf = eovf; x.lat = lat; x.start = cyc;
        sb.push_back(x);
        N = ~n;
        D = ~d;
        if (!hold) en = 1'b0;
        check("busy_start", 32'(busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (flag) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL flag_timeout: flag=%b required 1 within 100 cycles", flag);
        end
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("hold_flag", 32'(flag), 32'd1);
                check("hold_Q", 32'(Q), 32'(eq));
            end
            en = 1'b0;
        end
        @(negedge clk);
        check("exit_flag", 32'(flag), 32'd0);
        check("exit_busy", 32'(busy), 32'd0);
        check("exit_Q", 32'(Q), 32'(eq));
        check("exit_R", 32'(R), 32'(er));
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        N   = '0;
        D   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_Q", 32'(Q), 32'd0);
        check("rst_R", 32'(R), 32'd0);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd100,         16'd7,      16'h000E, 16'h0002, 1'b0, 1'b0, 34, 1'b0);
        run_op(32'hFFFF_FF9C,   16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 34, 1'b0);
        run_op(32'd100,         16'hFFF9,   16'hFFF2, 16'h0002, 1'b0, 1'b0, 34, 1'b0);
        run_op(32'hFFFF_FF9C,   16'hFFF9,   16'h000E, 16'hFFFE, 1'b0, 1'b0, 34, 1'b0);
        run_op(32'd1234,        16'd0,      16'hFFFF, 16'h04D2, 1'b1, 1'b0, 2,  1'b0);
        run_op(32'hFFFF_FFFB,   16'd0,      16'hFFFF, 16'hFFFB, 1'b1, 1'b0, 2,  1'b0);
`ifdef DIV_OVF_SATURATE_EN
        run_op(32'h7FFF_FFFF,   16'd1,      16'h7FFF, 16'h0000, 1'b0, 1'b1, 34, 1'b0);
        run_op(32'h8000_0000,   16'h8000,   16'h7FFF, 16'h0000, 1'b0, 1'b1, 34, 1'b0);
`else
        run_op(32'h7FFF_FFFF,   16'd1,      16'hFFFF, 16'h0000, 1'b0, 1'b0, 34, 1'b0);
        run_op(32'h8000_0000,   16'h8000,   16'h0000, 16'h0000, 1'b0, 1'b0, 34, 1'b0);
`endif
        run_op(32'hFFFF_8000,   16'd1,      16'h8000, 16'h0000, 1'b0, 1'b0, 34, 1'b0);
        run_op(32'hFFFF_FFFF,   16'd2,      16'h0000, 16'hFFFF, 1'b0, 1'b0, 34, 1'b0);
        run_op(32'd0,           16'hFFFB,   16'h0000, 16'h0000, 1'b0, 1'b0, 34, 1'b0);
        run_op(32'd1000,        16'd10,     16'h0064, 16'h0000, 1'b0, 1'b0, 34, 1'b1);

        // Abort mid-calculation: rst sampled at edge L+10
        @(negedge clk);
        N  = 32'd500;
        D  = 16'd3;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_Q", 32'(Q), 32'd0);
        check("abort_R", 32'(R), 32'd0);
        check("abort_flag", 32'(flag), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dbz", 32'(dbz), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd9,           16'hFFFE,   16'hFFFC, 16'h0001, 1'b0, 1'b0, 34, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
